net_pair_fifo: RTL and testbench

- Buffering stage directly upstream of the two-net pass-through connector. It accepts lane pairs (lane 1, lane 2) through an enqueue method and holds them in a circular buffer.
- The head pair drives first1/first2, which wire straight into IN1/IN2 of the connector.
- Enqueue and dequeue use the codebase's __ENA/__RDY method handshake. The block decouples the producer rule from the connector's consumer rule.

---
 rtl/net_pair_fifo.sv | 71 +++++++
 tb/tb_net_pair_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_pair_fifo.sv
// Circular pair buffer that feeds the two-net connector. It uses the __ENA/__RDY handshake,
// has no bypass path, and keeps a sticky protocol-violation flag.
module net_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq__ENA,
    output logic             enq__RDY,
    input  logic [WIDTH-1:0] enq_v1,
    input  logic [WIDTH-1:0] enq_v2,
    input  logic             deq__ENA,
    output logic             deq__RDY,
    output logic [WIDTH-1:0] first1,
    output logic [WIDTH-1:0] first2,
    output logic [CW-1:0]    count,
    output logic             err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] mem2 [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             enq_ok;
    logic             deq_ok;
    logic             bad_op;

    // Readiness comes from registered occupancy only, so a full FIFO cannot accept in the same edge it drains.
    assign enq__RDY = (count != FULL);
    assign deq__RDY = (count != '0);

    assign enq_ok = enq__ENA & enq__RDY;
    assign deq_ok = deq__ENA & deq__RDY;
    assign bad_op = (enq__ENA & ~enq__RDY) | (deq__ENA & ~deq__RDY);

    assign first1 = deq__RDY ? mem1[rd_ptr] : '0;
    assign first2 = deq__RDY ? mem2[rd_ptr] : '0;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem1[i] <= '0;
                mem2[i] <= '0;
            end
        end else begin
            if (enq_ok) begin
                mem1[wr_ptr] <= enq_v1;
                mem2[wr_ptr] <= enq_v2;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (deq_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (enq_ok && !deq_ok)
                count <= count + 1'b1;
            else if (deq_ok && !enq_ok)
                count <= count - 1'b1;
            if (bad_op)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_net_pair_fifo.sv
// Directed bench for net_pair_fifo. It drives a DEPTH=4/WIDTH=1 instance
// and a DEPTH=2/WIDTH=8 instance.
module tb_net_pair_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enq_ena = 1'b0, deq_ena = 1'b0;
    logic       enq_v1 = 1'b0, enq_v2 = 1'b0;
    logic       enq_rdy, deq_rdy, first1, first2, err;
    logic [2:0] count;

    logic       e8_ena = 1'b0, d8_ena = 1'b0;
    logic [7:0] e8_v1 = '0, e8_v2 = '0;
    logic       e8_rdy, d8_rdy, err8;
    logic [7:0] f8_1, f8_2;
    logic [1:0] count8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    net_pair_fifo #(.DEPTH(4), .WIDTH(1)) dut (
        .CLK(clk), .nRST(rst),
        .enq__ENA(enq_ena), .enq__RDY(enq_rdy), .enq_v1(enq_v1), .enq_v2(enq_v2),
        .deq__ENA(deq_ena), .deq__RDY(deq_rdy),
        .first1(first1), .first2(first2), .count(count), .err(err)
    );

    net_pair_fifo #(.DEPTH(2), .WIDTH(8)) dut8 (
        .CLK(clk), .nRST(rst),
        .enq__ENA(e8_ena), .enq__RDY(e8_rdy), .enq_v1(e8_v1), .enq_v2(e8_v2),
        .deq__ENA(d8_ena), .deq__RDY(d8_rdy),
        .first1(f8_1), .first2(f8_2), .count(count8), .err(err8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({enq_rdy, deq_rdy, count, first1, first2, err} !== 8'b1_0_000_0_0_0) begin
            failures++;
            $display("FAIL reset_during got rdy=%b/%b cnt=%0d f=%b%b err=%b want 1/0 0 00 0",
                     enq_rdy, deq_rdy, count, first1, first2, err);
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({enq_rdy, deq_rdy, count, first1, first2, err} !== 8'b1_0_000_0_0_0) begin
            failures++;
            $display("FAIL reset_idle got rdy=%b/%b cnt=%0d f=%b%b err=%b want 1/0 0 00 0",
                     enq_rdy, deq_rdy, count, first1, first2, err);
        end
    endtask

    task automatic test_fill_drain;
        logic [1:0] pairs [4];
        pairs = '{2'b10, 2'b01, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) begin
            enq_ena = 1'b1;
            {enq_v1, enq_v2} = pairs[i];
            // The empty FIFO must not offer dequeue while the first enqueue is in flight.
            if (i == 0) begin
                checks++;
                if (deq_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL no_bypass_empty deq_rdy=%b want 0", deq_rdy);
                end
            end
            tick();
            checks++;
            if (count !== 3'(i + 1)) begin
                failures++;
                $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1);
            end
            if (i == 0) begin
                checks++;
                if ({first1, first2} !== 2'b10) begin
                    failures++;
                    $display("FAIL fill_head_latency got %b%b want 10", first1, first2);
                end
            end
        end
        enq_ena = 1'b0;
        checks++;
        if (enq_rdy !== 1'b0) begin
            failures++;
            $display("FAIL full_enq_rdy got %b want 0", enq_rdy);
        end
        deq_ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({first1, first2} !== pairs[i]) begin
                failures++;
                $display("FAIL drain_head[%0d] got %b%b want %b", i, first1, first2, pairs[i]);
            end
            tick();
        end
        deq_ena = 1'b0;
        checks++;
        if ({count, deq_rdy, first1, first2} !== 6'b000_0_0_0) begin
            failures++;
            $display("FAIL drain_empty got cnt=%0d deq_rdy=%b f=%b%b want 0 0 00",
                     count, deq_rdy, first1, first2);
        end
    endtask

    task automatic test_wrap;
        logic [1:0] q[$];
        logic [1:0] seq [6];
        seq = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10};
        enq_ena = 1'b1;
        {enq_v1, enq_v2} = 2'b01; q.push_back(2'b01); tick();
        {enq_v1, enq_v2} = 2'b10; q.push_back(2'b10); tick();
        deq_ena = 1'b1;
        for (int i = 0; i < 6; i++) begin
            {enq_v1, enq_v2} = seq[i];
            checks++;
            if ({first1, first2} !== q[0]) begin
                failures++;
                $display("FAIL wrap_head[%0d] got %b%b want %b", i, first1, first2, q[0]);
            end
            void'(q.pop_front());
            q.push_back(seq[i]);
            tick();
            checks++;
            if (count !== 3'd2) begin
                failures++;
                $display("FAIL wrap_count[%0d] got %0d want 2", i, count);
            end
        end
        enq_ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({first1, first2} !== q[0]) begin
                failures++;
                $display("FAIL wrap_drain[%0d] got %b%b want %b", i, first1, first2, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        deq_ena = 1'b0;
        checks++;
        if ({count, err} !== 4'b000_0) begin
            failures++;
            $display("FAIL wrap_end got cnt=%0d err=%b want 0 0", count, err);
        end
    endtask

    task automatic test_violations;
        logic [1:0] pairs [4];
        pairs = '{2'b01, 2'b10, 2'b00, 2'b01};
        enq_ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {enq_v1, enq_v2} = pairs[i];
            tick();
        end
        {enq_v1, enq_v2} = 2'b11;
        tick();
        enq_ena = 1'b0;
        checks++;
        if ({err, count} !== 4'b1_100) begin
            failures++;
            $display("FAIL enq_overflow got err=%b cnt=%0d want 1 4", err, count);
        end
        deq_ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({first1, first2} !== pairs[i]) begin
                failures++;
                $display("FAIL overflow_data[%0d] got %b%b want %b", i, first1, first2, pairs[i]);
            end
            tick();
        end
        deq_ena = 1'b0;
        pulse_reset();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared got %b want 0", err);
        end
        deq_ena = 1'b1;
        tick();
        deq_ena = 1'b0;
        checks++;
        if ({err, count} !== 4'b1_000) begin
            failures++;
            $display("FAIL deq_underflow got err=%b cnt=%0d want 1 0", err, count);
        end
        // An illegal dequeue must not block a legal enqueue that happens on the same edge.
        pulse_reset();
        enq_ena = 1'b1; deq_ena = 1'b1; {enq_v1, enq_v2} = 2'b11;
        tick();
        enq_ena = 1'b0; deq_ena = 1'b0;
        checks++;
        if ({err, count, first1, first2} !== 6'b1_001_1_1) begin
            failures++;
            $display("FAIL mixed_violation got err=%b cnt=%0d f=%b%b want 1 1 11",
                     err, count, first1, first2);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid;
        enq_ena = 1'b1;
        {enq_v1, enq_v2} = 2'b11;
        repeat (3) tick();
        enq_ena = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({count, first1, first2} !== 5'b000_0_0) begin
            failures++;
            $display("FAIL reset_mid got cnt=%0d f=%b%b want 0 00", count, first1, first2);
        end
        // Hold an enable through an edge where reset is active. That enqueue must be ignored.
        enq_ena = 1'b1;
        tick();
        enq_ena = 1'b0;
        rst = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL reset_edge_ena got cnt=%0d want 0", count);
        end
        enq_ena = 1'b1;
        {enq_v1, enq_v2} = 2'b01;
        tick();
        enq_ena = 1'b0;
        checks++;
        if ({count, first1, first2} !== 5'b001_0_1) begin
            failures++;
            $display("FAIL reset_mid_enq got cnt=%0d f=%b%b want 1 01", count, first1, first2);
        end
    endtask

    task automatic test_wide;
        e8_ena = 1'b1;
        e8_v1 = 8'hA5; e8_v2 = 8'h3C;
        tick();
        e8_v1 = 8'hFF; e8_v2 = 8'h00;
        tick();
        e8_ena = 1'b0;
        checks++;
        if ({e8_rdy, count8} !== 3'b0_10) begin
            failures++;
            $display("FAIL wide_full got rdy=%b cnt=%0d want 0 2", e8_rdy, count8);
        end
        d8_ena = 1'b1;
        checks++;
        if ({f8_1, f8_2} !== 16'hA53C) begin
            failures++;
            $display("FAIL wide_head0 got %h%h want a53c", f8_1, f8_2);
        end
        tick();
        checks++;
        if ({f8_1, f8_2} !== 16'hFF00) begin
            failures++;
            $display("FAIL wide_head1 got %h%h want ff00", f8_1, f8_2);
        end
        tick();
        d8_ena = 1'b0;
        checks++;
        if ({count8, d8_rdy, err8, f8_1, f8_2} !== 20'h0_0000) begin
            failures++;
            $display("FAIL wide_empty got cnt=%0d rdy=%b err=%b f=%h%h want 0 0 0 0000",
                     count8, d8_rdy, err8, f8_1, f8_2);
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_violations();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
